// File: rtl/vision_pkg.sv
// Shared types for the descriptor loader: loader state, default-config
// widths and the default fixed-point pixel type.
package vision_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FINAL = 2'd1,
        HOLD  = 2'd2
    } desc_state_t;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_DESC_DIM = 8;
    localparam int DEF_PPW      = 4;
    localparam int DEF_INT_W    = 9;
    localparam int DEF_FRAC_W   = 27;
    localparam int DEF_N        = DEF_DESC_DIM * DEF_DESC_DIM;
    localparam int LOG_N        = $clog2(DEF_N);
    localparam int SUM_W        = DEF_PIX_W + LOG_N;
    localparam int SQ_W         = 2 * DEF_PIX_W + LOG_N;
    localparam int CNT_W        = $clog2(DEF_N / DEF_PPW) + 1;

    typedef logic signed [DEF_INT_W+DEF_FRAC_W-1:0] fx_t;

endpackage

// File: rtl/desc_word_accum.sv
// Combinational per-word reduction: pixel sum and sum of squares.
// Ports: in_word (packed pixels), word_sum, word_sq.
module desc_word_accum #(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int WS_W         = PIX_W + $clog2(PIX_PER_WORD + 1),
    parameter int WQ_W         = 2 * PIX_W + $clog2(PIX_PER_WORD + 1)
) (
    input  logic [PIX_W*PIX_PER_WORD-1:0] in_word,
    output logic [WS_W-1:0]               word_sum,
    output logic [WQ_W-1:0]               word_sq
);

    always_comb begin
        word_sum = '0;
        word_sq  = '0;
        for (int k = 0; k < PIX_PER_WORD; k++) begin
            word_sum = word_sum + WS_W'(in_word[k*PIX_W +: PIX_W]);
            word_sq  = word_sq
                     + WQ_W'(in_word[k*PIX_W +: PIX_W])
                     * WQ_W'(in_word[k*PIX_W +: PIX_W]);
        end
    end

endmodule

// File: rtl/desc_zm_loader.sv
// Descriptor loader: packs pixel words into an N-pixel descriptor, then
// presents zero-mean fixed-point pixels, raw sum and energy until acked.
// Ports: clk, rst (async high), clear, in_valid/in_ready/in_data,
// desc_valid/desc_ack, desc_pix, desc_sum, desc_energy, word_cnt.
module desc_zm_loader
    import vision_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int DESC_DIM     = 8,
    parameter int INT_W        = 9,
    parameter int FRAC_W       = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    output logic in_ready,
    input  logic [PIX_W*PIX_PER_WORD-1:0] in_data,
    output logic desc_valid,
    input  logic desc_ack,
    output logic [DESC_DIM*DESC_DIM-1:0][INT_W+FRAC_W-1:0] desc_pix,
    output logic [PIX_W+$clog2(DESC_DIM*DESC_DIM)-1:0] desc_sum,
    output logic [2*PIX_W+$clog2(DESC_DIM*DESC_DIM)-1:0] desc_energy,
    output logic [$clog2(DESC_DIM*DESC_DIM/PIX_PER_WORD):0] word_cnt
);

    localparam int N      = DESC_DIM * DESC_DIM;
    localparam int LOGN   = $clog2(N);
    localparam int WORDS  = N / PIX_PER_WORD;
    localparam int CW     = $clog2(WORDS) + 1;
    localparam int IDX_W  = CW - 1;
    localparam int SW     = PIX_W + LOGN;
    localparam int QW     = 2 * PIX_W + LOGN;
    localparam int OUT_W  = INT_W + FRAC_W;
    localparam int WS_W   = PIX_W + $clog2(PIX_PER_WORD + 1);
    localparam int WQ_W   = 2 * PIX_W + $clog2(PIX_PER_WORD + 1);
    localparam int SQF_W  = 2 * SW;

    desc_state_t state_q, state_d;
    logic in_ready_q, in_ready_d;
    logic desc_valid_q, desc_valid_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [QW-1:0] sumsq_q, sumsq_d;
    logic [PIX_W-1:0] pix_q [N];
    logic [PIX_W-1:0] pix_d [N];
    logic [N-1:0][OUT_W-1:0] dpix_q, dpix_d;
    logic [SW-1:0] dsum_q, dsum_d;
    logic [QW-1:0] energy_q, energy_d;

    logic [WS_W-1:0] word_sum;
    logic [WQ_W-1:0] word_sq;
    logic [IDX_W-1:0] widx;
    logic [OUT_W-1:0] mean_term;
    logic [SQF_W-1:0] sum_sq_full;
    logic hs;

    desc_word_accum #(
        .PIX_W(PIX_W),
        .PIX_PER_WORD(PIX_PER_WORD),
        .WS_W(WS_W),
        .WQ_W(WQ_W)
    ) u_accum (
        .in_word(in_data),
        .word_sum(word_sum),
        .word_sq(word_sq)
    );

    // in_ready is only ever high in FILL, so it alone qualifies the handshake.
    assign hs   = in_valid & in_ready_q;
    assign widx = word_cnt_q[IDX_W-1:0];

    // Mean in INT.FRAC: sum/N << FRAC_W, exact because FRAC_W >= log2(N).
    assign mean_term   = OUT_W'(sum_q) << (FRAC_W - LOGN);
    assign sum_sq_full = SQF_W'(sum_q) * SQF_W'(sum_q);

    always_comb begin
        state_d      = state_q;
        in_ready_d   = in_ready_q;
        desc_valid_d = desc_valid_q;
        word_cnt_d   = word_cnt_q;
        sum_d        = sum_q;
        sumsq_d      = sumsq_q;
        pix_d        = pix_q;
        dpix_d       = dpix_q;
        dsum_d       = dsum_q;
        energy_d     = energy_q;
        if (clear) begin
            state_d      = FILL;
            in_ready_d   = 1'b1;
            desc_valid_d = 1'b0;
            word_cnt_d   = '0;
            sum_d        = '0;
            sumsq_d      = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (hs) begin
                        // Pixel 0 of the word sits in the MSBs.
                        for (int w = 0; w < WORDS; w++) begin
                            if (widx == IDX_W'(w)) begin
                                for (int k = 0; k < PIX_PER_WORD; k++) begin
                                    pix_d[w*PIX_PER_WORD+k] =
                                        in_data[(PIX_PER_WORD-1-k)*PIX_W +: PIX_W];
                                end
                            end
                        end
                        sum_d   = sum_q + SW'(word_sum);
                        sumsq_d = sumsq_q + QW'(word_sq);
                        if (word_cnt_q != CW'(WORDS)) begin
                            word_cnt_d = word_cnt_q + 1'b1;
                        end
                        if (word_cnt_q == CW'(WORDS - 1)) begin
                            state_d    = FINAL;
                            in_ready_d = 1'b0;
                        end
                    end
                end
                FINAL: begin
                    for (int i = 0; i < N; i++) begin
                        dpix_d[i] = (OUT_W'(pix_q[i]) << FRAC_W) - mean_term;
                    end
                    dsum_d       = sum_q;
                    // floor(sum^2/N) <= sumsq, so the difference never underflows.
                    energy_d     = sumsq_q - QW'(sum_sq_full >> LOGN);
                    desc_valid_d = 1'b1;
                    state_d      = HOLD;
                end
                HOLD: begin
                    if (desc_ack) begin
                        desc_valid_d = 1'b0;
                        word_cnt_d   = '0;
                        sum_d        = '0;
                        sumsq_d      = '0;
                        in_ready_d   = 1'b1;
                        state_d      = FILL;
                    end
                end
                default: begin
                    state_d    = FILL;
                    in_ready_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            in_ready_q   <= 1'b1;
            desc_valid_q <= 1'b0;
            word_cnt_q   <= '0;
            sum_q        <= '0;
            sumsq_q      <= '0;
            for (int i = 0; i < N; i++) begin
                pix_q[i] <= '0;
            end
            dpix_q       <= '0;
            dsum_q       <= '0;
            energy_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            desc_valid_q <= desc_valid_d;
            word_cnt_q   <= word_cnt_d;
            sum_q        <= sum_d;
            sumsq_q      <= sumsq_d;
            pix_q        <= pix_d;
            dpix_q       <= dpix_d;
            dsum_q       <= dsum_d;
            energy_q     <= energy_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign desc_valid  = desc_valid_q;
    assign word_cnt    = word_cnt_q;
    assign desc_pix    = dpix_q;
    assign desc_sum    = dsum_q;
    assign desc_energy = energy_q;

endmodule

// File: tb/tb_desc_zm_loader.sv
// Self-checking bench for desc_zm_loader (default parameters) against
// an arithmetic model of the descriptor statistics.
module tb_desc_zm_loader;

    localparam int PIX_W  = 8;
    localparam int PPW    = 4;
    localparam int DIM    = 8;
    localparam int INT_W  = 9;
    localparam int FRAC_W = 27;
    localparam int N      = DIM * DIM;
    localparam int LOGN   = 6;
    localparam int WORDS  = N / PPW;
    localparam int WW     = PIX_W * PPW;
    localparam int OUT_W  = INT_W + FRAC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [WW-1:0] in_data = '0;
    logic desc_valid;
    logic desc_ack = 1'b0;
    logic [N-1:0][OUT_W-1:0] desc_pix;
    logic [PIX_W+LOGN-1:0] desc_sum;
    logic [2*PIX_W+LOGN-1:0] desc_energy;
    logic [LOGN-$clog2(PPW):0] word_cnt;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] cur_words [WORDS];
    longint exp_pix [N];
    longint exp_sum;
    longint exp_energy;

    desc_zm_loader #(
        .PIX_W(PIX_W), .PIX_PER_WORD(PPW), .DESC_DIM(DIM),
        .INT_W(INT_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .desc_valid(desc_valid), .desc_ack(desc_ack),
        .desc_pix(desc_pix), .desc_sum(desc_sum),
        .desc_energy(desc_energy), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // mean = sum/N, so (p - mean) * 2^FRAC_W = (p*N - sum) * 2^(FRAC_W-LOGN).
    function automatic void model();
        longint pv [N];
        longint s = 0;
        longint sq = 0;
        for (int w = 0; w < WORDS; w++) begin
            for (int k = 0; k < PPW; k++) begin
                pv[w*PPW+k] = longint'((cur_words[w] >> ((PPW-1-k)*PIX_W)) & 32'hFF);
                s  += pv[w*PPW+k];
                sq += pv[w*PPW+k] * pv[w*PPW+k];
            end
        end
        exp_sum    = s;
        exp_energy = sq - (s * s) / N;
        for (int i = 0; i < N; i++) begin
            exp_pix[i] = (pv[i] * N - s) * (longint'(1) << (FRAC_W - LOGN));
        end
    endfunction

    task automatic fill_const(input logic [WW-1:0] w);
        for (int i = 0; i < WORDS; i++) cur_words[i] = w;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < WORDS; i++) cur_words[i] = $urandom;
    endtask

    task automatic send_word(input logic [WW-1:0] w);
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = w;
        for (int c = 0; c < 50 && !ok; c++) begin
            ok = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL handshake_timeout got in_ready=0 want 1");
        end
    endtask

    // gap: 0 none, 1 one idle cycle, 2 random idle cycles
    task automatic load_words(input int gap);
        for (int w = 0; w < WORDS; w++) begin
            send_word(cur_words[w]);
            if (w < WORDS - 1) begin
                if (gap == 1) begin
                    @(posedge clk); #1;
                end else if (gap == 2) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    endtask

    task automatic wait_valid();
        for (int c = 0; c < 20 && desc_valid !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        if (desc_valid !== 1'b1) begin
            errors++;
            $display("FAIL desc_valid_timeout got %b want 1", desc_valid);
        end
    endtask

    task automatic ack_desc();
        desc_ack = 1'b1;
        @(posedge clk); #1;
        desc_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || desc_valid !== 1'b0 || word_cnt !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got rdy=%b vld=%b cnt=%0d want 1 0 0",
                     in_ready, desc_valid, word_cnt);
        end
        checks++;
        if (desc_sum !== '0 || desc_energy !== '0 || desc_pix !== '0) begin
            errors++;
            $display("FAIL reset_data got sum=%0d en=%0d want 0 0",
                     desc_sum, desc_energy);
        end
    endtask

    task automatic test_ramp(input string tag);
        fill_const({8'd1, 8'd2, 8'd4, 8'd5});
        model();
        load_words(0);
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_latency_early got %b want 0", tag, desc_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (desc_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency got %b want 1", tag, desc_valid);
        end
        checks++;
        if (desc_sum !== 14'd192 || longint'(desc_sum) != exp_sum) begin
            errors++;
            $display("FAIL %s_sum got %0d want 192", tag, desc_sum);
        end
        checks++;
        if (desc_energy !== 22'd160 || longint'(desc_energy) != exp_energy) begin
            errors++;
            $display("FAIL %s_energy got %0d want 160", tag, desc_energy);
        end
        checks++;
        if (longint'($signed(desc_pix[0])) != -(longint'(2) << 27)) begin
            errors++;
            $display("FAIL %s_pix0 got %0d want %0d", tag,
                     longint'($signed(desc_pix[0])), -(longint'(2) << 27));
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (longint'($signed(desc_pix[i])) != exp_pix[i]) begin
                errors++;
                $display("FAIL %s_pix[%0d] got %0d want %0d", tag, i,
                         longint'($signed(desc_pix[i])), exp_pix[i]);
            end
        end
        checks++;
        if (word_cnt !== 5'd16 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold got cnt=%0d rdy=%b want 16 0", tag, word_cnt, in_ready);
        end
        ack_desc();
        checks++;
        if (desc_valid !== 1'b0 || word_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ack got vld=%b cnt=%0d rdy=%b want 0 0 1", tag,
                     desc_valid, word_cnt, in_ready);
        end
    endtask

    task automatic test_const();
        fill_const({4{8'd255}});
        model();
        load_words(0);
        wait_valid();
        checks++;
        if (desc_sum !== 14'd16320 || desc_energy !== '0) begin
            errors++;
            $display("FAIL const_stats got sum=%0d en=%0d want 16320 0",
                     desc_sum, desc_energy);
        end
        checks++;
        if (desc_pix !== '0) begin
            errors++;
            $display("FAIL const_pix got %0d want 0", longint'($signed(desc_pix[0])));
        end
        ack_desc();
    endtask

    task automatic test_back_pressure();
        logic [PIX_W+LOGN-1:0] s_sum;
        logic [2*PIX_W+LOGN-1:0] s_en;
        logic [N-1:0][OUT_W-1:0] s_pix;
        fill_rand();
        model();
        load_words(0);
        wait_valid();
        s_sum = desc_sum;
        s_en  = desc_energy;
        s_pix = desc_pix;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = $urandom;
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || desc_valid !== 1'b1 || desc_sum !== s_sum
                || desc_energy !== s_en || desc_pix !== s_pix) begin
                errors++;
                $display("FAIL bp_stable c=%0d got rdy=%b vld=%b sum=%0d want 0 1 %0d",
                         c, in_ready, desc_valid, desc_sum, s_sum);
            end
        end
        checks++;
        if (longint'(s_sum) != exp_sum || longint'(s_en) != exp_energy) begin
            errors++;
            $display("FAIL bp_model got sum=%0d en=%0d want %0d %0d",
                     s_sum, s_en, exp_sum, exp_energy);
        end
        ack_desc();
        in_valid = 1'b0;
        checks++;
        if (word_cnt !== '0 || in_ready !== 1'b1 || desc_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ack_edge got cnt=%0d rdy=%b vld=%b want 0 1 0",
                     word_cnt, in_ready, desc_valid);
        end
        fill_rand();
        model();
        load_words(0);
        wait_valid();
        checks++;
        if (longint'(desc_sum) != exp_sum || longint'(desc_energy) != exp_energy) begin
            errors++;
            $display("FAIL bp_next got sum=%0d en=%0d want %0d %0d",
                     desc_sum, desc_energy, exp_sum, exp_energy);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (longint'($signed(desc_pix[i])) != exp_pix[i]) begin
                errors++;
                $display("FAIL bp_pix[%0d] got %0d want %0d", i,
                         longint'($signed(desc_pix[i])), exp_pix[i]);
            end
        end
        ack_desc();
    endtask

    task automatic test_gapped();
        fill_const({8'd1, 8'd2, 8'd4, 8'd5});
        cur_words[0] = {8'd8, 8'd16, 8'd32, 8'd64};
        model();
        for (int w = 0; w < WORDS; w++) begin
            send_word(cur_words[w]);
            checks++;
            if (int'(word_cnt) != w + 1) begin
                errors++;
                $display("FAIL gap_cnt w=%0d got %0d want %0d", w, word_cnt, w + 1);
            end
            if (w < WORDS - 1) begin
                desc_ack = 1'b1;
                @(posedge clk); #1;
                desc_ack = 1'b0;
                checks++;
                if (int'(word_cnt) != w + 1) begin
                    errors++;
                    $display("FAIL gap_idle w=%0d got %0d want %0d", w, word_cnt, w + 1);
                end
            end
        end
        wait_valid();
        checks++;
        if (desc_sum !== 14'd300 || longint'(desc_energy) != exp_energy) begin
            errors++;
            $display("FAIL gap_stats got sum=%0d en=%0d want 300 %0d",
                     desc_sum, desc_energy, exp_energy);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (longint'($signed(desc_pix[i])) != exp_pix[i]) begin
                errors++;
                $display("FAIL gap_pix[%0d] got %0d want %0d", i,
                         longint'($signed(desc_pix[i])), exp_pix[i]);
            end
        end
        ack_desc();
    endtask

    task automatic test_reset_mid_fill();
        fill_rand();
        for (int w = 0; w < 5; w++) send_word(cur_words[w]);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (desc_valid !== 1'b0 || word_cnt !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid got vld=%b cnt=%0d rdy=%b want 0 0 1",
                     desc_valid, word_cnt, in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        test_ramp("rst_ramp");
    endtask

    task automatic test_clear();
        fill_rand();
        for (int w = 0; w < 3; w++) send_word(cur_words[w]);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = $urandom;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (word_cnt !== '0 || desc_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_fill got cnt=%0d vld=%b rdy=%b want 0 0 1",
                     word_cnt, desc_valid, in_ready);
        end
        load_words(0);
        wait_valid();
        clear = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (word_cnt !== '0 || desc_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_hold got cnt=%0d vld=%b rdy=%b want 0 0 1",
                     word_cnt, desc_valid, in_ready);
        end
        fill_rand();
        model();
        load_words(0);
        wait_valid();
        checks++;
        if (longint'(desc_sum) != exp_sum || longint'(desc_energy) != exp_energy) begin
            errors++;
            $display("FAIL clr_next got sum=%0d en=%0d want %0d %0d",
                     desc_sum, desc_energy, exp_sum, exp_energy);
        end
        ack_desc();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            fill_rand();
            model();
            load_words(2);
            wait_valid();
            checks++;
            if (longint'(desc_sum) != exp_sum || longint'(desc_energy) != exp_energy) begin
                errors++;
                $display("FAIL rnd%0d_stats got sum=%0d en=%0d want %0d %0d", r,
                         desc_sum, desc_energy, exp_sum, exp_energy);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (longint'($signed(desc_pix[i])) != exp_pix[i]) begin
                    errors++;
                    $display("FAIL rnd%0d_pix[%0d] got %0d want %0d", r, i,
                             longint'($signed(desc_pix[i])), exp_pix[i]);
                end
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            ack_desc();
        end
    endtask

    initial begin
        test_reset();
        test_ramp("ramp");
        test_const();
        test_back_pressure();
        test_gapped();
        test_reset_mid_fill();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
